iht: RTL and testbench

- Inverse Walsh-Hadamard transform, i.e. the decoder for the forward `ht` block.
- Accepts one vector of INDEX signed coefficients, runs LOG_N in-place butterfly stages (one per cycle), divides by INDEX and returns the recovered unsigned samples with a one-cycle `over` pulse.
- Sits at the output of `ht` so the bench and the integrated datapath can perform a round-trip check (indata -> ht -> iht -> indata).

---
 rtl/ht_pkg.sv | 35 +++
 rtl/iht_if.sv | 23 ++
 rtl/iht_bfly.sv | 14 +
 rtl/iht.sv | 122 ++++++++++++
 tb/tb_iht.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ht_pkg.sv
// Shared parameters, state encoding and index helpers for the Hadamard
// transform pair (ht forward, iht inverse).
package ht_pkg;

    localparam int WIDTH = 4;
    localparam int INDEX = 16;
    localparam int LOG_N = 4;
    localparam int CW    = WIDTH + LOG_N + 1;
    localparam int AW    = CW + LOG_N;
    localparam int SW    = (LOG_N > 1) ? $clog2(LOG_N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Lower element of butterfly pair k at stage s: insert a 0 at bit s of k.
    function automatic logic [LOG_N-1:0] pair_lo(input int k, input int s);
        return LOG_N'(((k >> s) << (s + 1)) | (k & ((1 << s) - 1)));
    endfunction

    function automatic logic [LOG_N-1:0] pair_hi(input int k, input int s);
        return LOG_N'((((k >> s) << (s + 1)) | (k & ((1 << s) - 1))) | (1 << s));
    endfunction

    function automatic int coef_lsb(input int i);
        return i * CW;
    endfunction

    function automatic int samp_lsb(input int i);
        return i * WIDTH;
    endfunction

endpackage

// File: rtl/iht_if.sv
// Request/response bundle between a coefficient source and the inverse
// Hadamard transform.
interface iht_if;
    import ht_pkg::*;

    logic                   start;
    logic [INDEX*CW-1:0]    in_coef;
    logic [INDEX*WIDTH-1:0] out_data;
    logic                   over;
    logic                   err;
    logic                   busy;

    modport master (
        output start, in_coef,
        input  out_data, over, err, busy
    );

    modport slave (
        input  start, in_coef,
        output out_data, over, err, busy
    );

endinterface

// File: rtl/iht_bfly.sv
// Single radix-2 Hadamard butterfly: sum and difference of two signed words.
module iht_bfly
    import ht_pkg::*;
(
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    output logic signed [AW-1:0] sum,
    output logic signed [AW-1:0] diff
);

    assign sum  = a + b;
    assign diff = a - b;

endmodule

// File: rtl/iht.sv
// Inverse Walsh-Hadamard transform: LOG_N in-place butterfly stages, one per
// cycle, then divide by INDEX with an integrity check on the result.
//
// state   | meaning
// IDLE    | waiting for start; coefficients captured on start
// RUN     | one butterfly stage per cycle, stride 2^stage
// DONE    | first cycle: scale into out_data and pulse over; second: return
module iht
    import ht_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    iht_if.slave bus
);

    localparam logic [SW-1:0]        LAST_STAGE = SW'(LOG_N - 1);
    localparam logic signed [AW-1:0] Q_MAX      = AW'((1 << WIDTH) - 1);

    state_t                 state;
    logic [SW-1:0]          stage;
    logic signed [AW-1:0]   buf_r   [INDEX];
    logic signed [AW-1:0]   nxt_buf [INDEX];
    logic signed [AW-1:0]   bf_a    [INDEX/2];
    logic signed [AW-1:0]   bf_b    [INDEX/2];
    logic signed [AW-1:0]   bf_s    [INDEX/2];
    logic signed [AW-1:0]   bf_d    [INDEX/2];
    logic [INDEX*WIDTH-1:0] out_r;
    logic [INDEX*WIDTH-1:0] out_nxt;
    logic                   over_r;
    logic                   err_r;
    logic                   err_nxt;

    for (genvar k = 0; k < INDEX/2; k++) begin : g_bfly
        iht_bfly u_bfly (
            .a    (bf_a[k]),
            .b    (bf_b[k]),
            .sum  (bf_s[k]),
            .diff (bf_d[k])
        );
    end

    always_comb begin
        for (int k = 0; k < INDEX/2; k++) begin
            bf_a[k] = buf_r[pair_lo(k, int'(stage))];
            bf_b[k] = buf_r[pair_hi(k, int'(stage))];
        end
    end

    always_comb begin
        nxt_buf = buf_r;
        for (int k = 0; k < INDEX/2; k++) begin
            nxt_buf[pair_lo(k, int'(stage))] = bf_s[k];
            nxt_buf[pair_hi(k, int'(stage))] = bf_d[k];
        end
    end

    // Valid result: exact multiple of INDEX whose quotient fits an unsigned sample.
    always_comb begin
        logic signed [AW-1:0] q;
        out_nxt = '0;
        err_nxt = 1'b0;
        q       = '0;
        for (int i = 0; i < INDEX; i++) begin
            q = buf_r[i] >>> LOG_N;
            if (buf_r[i][LOG_N-1:0] != '0 || q < 0 || q > Q_MAX) begin
                err_nxt = 1'b1;
            end
            out_nxt[samp_lsb(i) +: WIDTH] = q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            stage  <= '0;
            out_r  <= '0;
            over_r <= 1'b0;
            err_r  <= 1'b0;
            for (int i = 0; i < INDEX; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < INDEX; i++) begin
                            buf_r[i] <= AW'(signed'(bus.in_coef[coef_lsb(i) +: CW]));
                        end
                        stage <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    buf_r <= nxt_buf;
                    if (stage == LAST_STAGE) begin
                        stage <= '0;
                        state <= ST_DONE;
                    end else begin
                        stage <= stage + SW'(1);
                    end
                end
                ST_DONE: begin
                    if (!over_r) begin
                        out_r  <= out_nxt;
                        err_r  <= err_nxt;
                        over_r <= 1'b1;
                    end else begin
                        over_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_data = out_r;
    assign bus.over     = over_r;
    assign bus.err      = err_r;
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_iht.sv
// Scoreboard bench for iht: reference transform computed from the matrix
// definition, expected results queued at issue and checked on every over.
module tb_iht;
    import ht_pkg::*;

    typedef int vec_t [INDEX];
    typedef struct {
        logic [INDEX*WIDTH-1:0] data;
        logic                   err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iht_if bus ();

    iht dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t fwd(input vec_t x);
        vec_t c;
        for (int j = 0; j < INDEX; j++) begin
            c[j] = 0;
            for (int i = 0; i < INDEX; i++) begin
                c[j] += ($countones(i & j) % 2 == 1) ? -x[i] : x[i];
            end
        end
        return c;
    endfunction

    function automatic exp_t model(input vec_t c);
        exp_t e;
        int   v, r, q;
        e.data = '0;
        e.err  = 1'b0;
        for (int i = 0; i < INDEX; i++) begin
            v = 0;
            for (int j = 0; j < INDEX; j++) begin
                v += ($countones(i & j) % 2 == 1) ? -c[j] : c[j];
            end
            r = ((v % INDEX) + INDEX) % INDEX;
            q = (v - r) / INDEX;
            if (r != 0 || q < 0 || q > (1 << WIDTH) - 1) e.err = 1'b1;
            e.data[i*WIDTH +: WIDTH] = WIDTH'(q);
        end
        return e;
    endfunction

    function automatic logic [INDEX*CW-1:0] pack_c(input vec_t c);
        logic [INDEX*CW-1:0] p;
        for (int i = 0; i < INDEX; i++) p[i*CW +: CW] = CW'(c[i]);
        return p;
    endfunction

    function automatic logic [INDEX*WIDTH-1:0] pack_x(input vec_t x);
        logic [INDEX*WIDTH-1:0] p;
        for (int i = 0; i < INDEX; i++) p[i*WIDTH +: WIDTH] = WIDTH'(x[i]);
        return p;
    endfunction

    function automatic vec_t rand_x();
        vec_t x;
        for (int i = 0; i < INDEX; i++) x[i] = int'($urandom_range(0, (1 << WIDTH) - 1));
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.over) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_over actual=1 required=0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("sb_data", 64'(bus.out_data), 64'(e.data));
                check("sb_err", 64'(bus.err), 64'(e.err));
            end
        end
    end

    task automatic start_txn(input vec_t c, input bit push);
        @(negedge clk);
        bus.in_coef = pack_c(c);
        bus.start   = 1'b1;
        if (push) sb.push_back(model(c));
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.in_coef = ~bus.in_coef;
    endtask

    // Waits for over counting edges since the start sample, then checks the hold cycle.
    task automatic wait_over(input int edges_done);
        int                     lat;
        bit                     seen;
        logic [INDEX*WIDTH-1:0] d;
        logic                   e;
        lat  = edges_done;
        seen = 1'b0;
        while (lat < 20 && !seen) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.over) seen = 1'b1;
        end
        check("latency", 64'(lat), 64'(LOG_N + 1));
        if (seen) begin
            check("busy_in_over", 64'(bus.busy), 64'd1);
            d = bus.out_data;
            e = bus.err;
            @(posedge clk);
            #1;
            check("over_pulse", 64'(bus.over), 64'd0);
            check("busy_after", 64'(bus.busy), 64'd0);
            check("data_hold", 64'(bus.out_data), 64'(d));
            check("err_hold", 64'(bus.err), 64'(e));
        end
    endtask

    initial begin
        vec_t x, c, xb, cb;
        bus.start   = 1'b0;
        bus.in_coef = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_over", 64'(bus.over), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;

        // impulse
        for (int i = 0; i < INDEX; i++) c[i] = 5;
        start_txn(c, 1'b1);
        wait_over(0);
        check("impulse_data", 64'(bus.out_data), 64'd5);
        check("impulse_err", 64'(bus.err), 64'd0);

        // ramp round trip
        for (int i = 0; i < INDEX; i++) x[i] = i;
        c = fwd(x);
        check("ramp_c0", 64'(c[0]), 64'd120);
        start_txn(c, 1'b1);
        wait_over(0);
        check("ramp_data", 64'(bus.out_data), 64'(pack_x(x)));
        check("ramp_err", 64'(bus.err), 64'd0);

        // random round trips
        for (int n = 0; n < 100; n++) begin
            x = rand_x();
            c = fwd(x);
            start_txn(c, 1'b1);
            wait_over(0);
            check("rt_data", 64'(bus.out_data), 64'(pack_x(x)));
            check("rt_err", 64'(bus.err), 64'd0);
        end

        // not divisible by INDEX
        for (int i = 0; i < INDEX; i++) c[i] = 0;
        c[0] = 1;
        start_txn(c, 1'b1);
        wait_over(0);
        check("div_err", 64'(bus.err), 64'd1);
        check("div_data", 64'(bus.out_data), 64'd0);

        // negative quotient, then a clean vector clears err
        for (int i = 0; i < INDEX; i++) c[i] = -1;
        start_txn(c, 1'b1);
        wait_over(0);
        check("range_err", 64'(bus.err), 64'd1);
        x = rand_x();
        start_txn(fwd(x), 1'b1);
        wait_over(0);
        check("range_clear", 64'(bus.err), 64'd0);
        check("range_clear_data", 64'(bus.out_data), 64'(pack_x(x)));

        // arbitrary coefficients, mostly invalid
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < INDEX; i++) c[i] = int'($urandom_range(0, 511)) - 256;
            start_txn(c, 1'b1);
            wait_over(0);
        end

        // start while busy is ignored
        x  = rand_x();
        xb = rand_x();
        xb[0] = (x[0] + 1) % (1 << WIDTH);
        c  = fwd(x);
        cb = fwd(xb);
        start_txn(c, 1'b1);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.in_coef = pack_c(cb);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        wait_over(2);
        check("busy_ignore_data", 64'(bus.out_data), 64'(pack_x(x)));

        // reset in flight discards the transform
        for (int i = 0; i < INDEX; i++) x[i] = (1 << WIDTH) - 1;
        start_txn(fwd(x), 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_data", 64'(bus.out_data), 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("midrst_over", 64'(bus.over), 64'd0);
        x = rand_x();
        start_txn(fwd(x), 1'b1);
        wait_over(0);
        check("post_rst_data", 64'(bus.out_data), 64'(pack_x(x)));

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
